// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module   : program_loader_pkg
// Purpose  : Shared state encoding and stream-format constants for the
//            boot-time program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam int C_HDR_BYTES  = 2;
    localparam int C_CSUM_BYTES = 1;
    localparam int C_WORD_BYTES = 4;

    // Byte address of instruction word 'index' in an image based at 'base'.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] index);
        return base + {14'd0, index, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ============================================================================
// Module   : program_loader_if
// Purpose  : Byte-stream handshake, instruction-memory write port and core
//            status signals of the program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface program_loader_if;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        core_reset;
    logic        done;
    logic        error;

    modport master (
        output load_start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wd, core_reset, done, error
    );

    modport slave (
        input  load_start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wd, core_reset, done, error
    );
endinterface

`default_nettype wire

// File: rtl/program_loader_byte_assembler.sv
// ============================================================================
// Module   : program_loader_byte_assembler
// Purpose  : Packs accepted bytes little-endian into 32-bit words and pulses
//            o_word_valid for one cycle when a word is complete.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader_byte_assembler (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clear,
    input  wire logic        i_accept,
    input  wire logic [7:0]  i_byte,
    output logic      [1:0]  o_lane,
    output logic      [31:0] o_word,
    output logic             o_word_valid
);

    logic [1:0]  r_lane;
    logic [23:0] r_partial;
    logic [31:0] r_word;
    logic        r_word_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane       <= 2'd0;
            r_partial    <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_lane    <= 2'd0;
                r_partial <= 24'd0;
            end else if (i_accept) begin
                case (r_lane)
                    2'd0: r_partial[7:0]   <= i_byte;
                    2'd1: r_partial[15:8]  <= i_byte;
                    2'd2: r_partial[23:16] <= i_byte;
                    2'd3: begin
                        r_word       <= {i_byte, r_partial};
                        r_word_valid <= 1'b1;
                    end
                    default: r_partial <= r_partial;
                endcase
                r_lane <= r_lane + 2'd1;
            end
        end
    end

    assign o_lane       = r_lane;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Purpose  : Receives a length-prefixed, XOR-checksummed byte image, writes it
//            into instruction memory and releases the core once verified.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    program_loader_if.slave bus
);

    localparam logic [15:0] c_max_words = 16'(MAX_WORDS);

    state_t      r_state;
    logic [7:0]  r_xor;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [15:0] r_index;
    logic [31:0] r_addr;
    logic        r_byte_ready;
    logic        r_core_reset;
    logic        r_done;
    logic        r_error;

    logic        w_accept;
    logic        w_start;
    logic        w_asm_accept;
    logic [15:0] w_len;
    logic        w_last_byte;
    logic [1:0]  w_lane;
    logic [31:0] w_word;
    logic        w_word_valid;

    assign w_accept     = bus.byte_valid && r_byte_ready;
    assign w_start      = bus.load_start &&
                          (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
    assign w_asm_accept = w_accept && (r_state == ST_DATA);
    assign w_len        = {bus.byte_data, r_len_lo};
    // Final data byte: lane 3 of the last word of the image.
    assign w_last_byte  = (w_lane == 2'd3) && (r_index == r_len - 16'd1);

    program_loader_byte_assembler u_byte_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start),
        .i_accept     (w_asm_accept),
        .i_byte       (bus.byte_data),
        .o_lane       (w_lane),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_xor        <= 8'd0;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_index      <= 16'd0;
            r_addr       <= BASE_ADDR;
            r_byte_ready <= 1'b0;
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_start) begin
                        r_state      <= ST_LEN_LO;
                        r_xor        <= 8'd0;
                        r_index      <= 16'd0;
                        r_byte_ready <= 1'b1;
                        r_core_reset <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= bus.byte_data;
                        r_xor    <= r_xor ^ bus.byte_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        r_xor <= r_xor ^ bus.byte_data;
                        if (w_len > c_max_words) begin
                            r_state      <= ST_ERR;
                            r_byte_ready <= 1'b0;
                            r_error      <= 1'b1;
                        end else if (w_len == 16'd0) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_xor <= r_xor ^ bus.byte_data;
                        // Address is latched alongside the assembled word so both reach memory together.
                        if (w_lane == 2'd3) begin
                            r_addr  <= word_addr(BASE_ADDR, r_index);
                            r_index <= r_index + 16'd1;
                        end
                        if (w_last_byte) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        r_byte_ready <= 1'b0;
                        if (bus.byte_data == r_xor) begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_core_reset <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.imem_we    = w_word_valid;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wd    = w_word;
    assign bus.core_reset = r_core_reset;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader: fixed stream vectors,
//            mid-load reset, and randomized images against a stream model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 64;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [127:0] stream;   // bytes in order, first byte most significant
        int           nb;
        logic         exp_done;
        logic         exp_err;
        int           exp_nw;
        logic [31:0]  w0;
        logic [31:0]  w1;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_writes = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write scoreboard: every imem_we pulse must match the next expected write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         bus.imem_addr, bus.imem_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.imem_addr !== e.addr || bus.imem_wd !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             bus.imem_addr, bus.imem_wd, e.addr, e.data);
                end
            end
        end
    end

    task automatic check_reset_values();
        check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_imem_we",    {31'd0, bus.imem_we},    32'd0);
        check("rst_imem_addr",  bus.imem_addr,           BASE);
        check("rst_imem_wd",    bus.imem_wd,             32'd0);
        check("rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
        check("rst_done",       {31'd0, bus.done},       32'd0);
        check("rst_error",      {31'd0, bus.error},      32'd0);
    endtask

    task automatic start_load();
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        check("start_byte_ready", {31'd0, bus.byte_ready}, 32'd1);
        check("start_done",       {31'd0, bus.done},       32'd0);
        check("start_error",      {31'd0, bus.error},      32'd0);
        check("start_core_reset", {31'd0, bus.core_reset}, 32'd1);
    endtask

    // Presents one byte (after optional idle gaps) and returns at the negedge
    // following the cycle in which it was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit spurious);
        int cyc;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.byte_valid = 1'b0;
            @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        bus.load_start = spurious;
        cyc = 0;
        while (bus.byte_ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got byte_ready %b expected 1", bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.load_start = 1'b0;
    endtask

    task automatic run_stream(input logic [7:0] s[$], input logic [31:0] ew[$],
                              input logic exp_done, input logic exp_err,
                              input int gap_pct, input int spur_pct);
        start_load();
        n_writes = 0;
        exp_q.delete();
        foreach (ew[k]) exp_q.push_back('{addr: BASE + 32'(k) * 32'd4, data: ew[k]});
        for (int i = 0; i < s.size(); i++) begin
            if (i == s.size() - 1) check("done_before_last", {31'd0, bus.done}, 32'd0);
            send_byte(s[i], gap_pct, ($urandom_range(99) < spur_pct));
        end
        check("end_done",       {31'd0, bus.done},       {31'd0, exp_done});
        check("end_error",      {31'd0, bus.error},      {31'd0, exp_err});
        check("end_core_reset", {31'd0, bus.core_reset}, {31'd0, !exp_done});
        check("end_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        #1;
        check("writes_drained", exp_q.size(), 32'd0);
        check("write_count",    n_writes,     ew.size());
    endtask

    vec_t        vecs[5];
    logic [7:0]  sq[$];
    logic [31:0] wq[$];

    initial begin
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'd0;
        rst = 1'b1;

        vecs[0] = '{128'h0200930050001381100043, 11, 1'b1, 1'b0, 2, 32'h00500093, 32'h00108113};
        vecs[1] = '{128'h000000,                  3, 1'b1, 1'b0, 0, 32'h0,        32'h0};
        vecs[2] = '{128'h4100,                    2, 1'b0, 1'b1, 0, 32'h0,        32'h0};
        vecs[3] = '{128'h0200930050001381100044, 11, 1'b0, 1'b1, 2, 32'h00500093, 32'h00108113};
        vecs[4] = '{128'h01007856341209,          7, 1'b1, 1'b0, 1, 32'h12345678, 32'h0};

        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            sq.delete();
            wq.delete();
            for (int i = 0; i < vecs[v].nb; i++)
                sq.push_back(vecs[v].stream[8 * (vecs[v].nb - 1 - i) +: 8]);
            if (vecs[v].exp_nw > 0) wq.push_back(vecs[v].w0);
            if (vecs[v].exp_nw > 1) wq.push_back(vecs[v].w1);
            run_stream(sq, wq, vecs[v].exp_done, vecs[v].exp_err, 0, 0);
        end

        // Reset mid-load: one full word plus a partial one, then a clean reload.
        start_load();
        n_writes = 0;
        exp_q.delete();
        exp_q.push_back('{addr: BASE, data: 32'h00500093});
        for (int i = 0; i < 7; i++) send_byte(vecs[0].stream[8 * (10 - i) +: 8], 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_write_count", n_writes, 32'd1);
        check("midrst_drained",     exp_q.size(), 32'd0);
        sq.delete();
        for (int i = 0; i < 11; i++) sq.push_back(vecs[0].stream[8 * (10 - i) +: 8]);
        wq.delete();
        wq.push_back(32'h00500093);
        wq.push_back(32'h00108113);
        run_stream(sq, wq, 1'b1, 1'b0, 0, 0);

        // Same image with ~50% valid gaps.
        run_stream(sq, wq, 1'b1, 1'b0, 50, 0);

        // Randomized images checked against a stream-level model.
        for (int it = 0; it < 16; it++) begin
            int         n;
            logic [7:0] x;
            logic       ok;
            n = (it == 0) ? MAXW : (it == 1) ? MAXW + 1 : int'($urandom_range(0, 6));
            sq.delete();
            wq.delete();
            sq.push_back(8'(n));
            sq.push_back(8'(n >> 8));
            if (n <= MAXW) begin
                for (int i = 0; i < 4 * n; i++) sq.push_back(8'($urandom_range(255)));
                x = 8'd0;
                foreach (sq[i]) x ^= sq[i];
                ok = ($urandom_range(3) != 0);
                if (!ok) x ^= 8'(1 << $urandom_range(7));
                sq.push_back(x);
                for (int k = 0; k < n; k++)
                    wq.push_back({sq[2 + 4 * k + 3], sq[2 + 4 * k + 2],
                                  sq[2 + 4 * k + 1], sq[2 + 4 * k]});
            end else begin
                ok = 1'b0;
            end
            run_stream(sq, wq, ok, !ok, 50, 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
